// File: rtl/pipeline_pkg.sv
// Shared definitions for the program loader: FSM states, host command bytes
// and the default instruction word that terminates a program load.
package pipeline_pkg;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    localparam logic [7:0] CMD_CONT   = 8'h63;
    localparam logic [7:0] CMD_STEP   = 8'h73;
    localparam logic [7:0] CMD_RELOAD = 8'h72;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_WAIT_CMD,
        ST_RUN,
        ST_STEP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs received bytes MSB first into a 32-bit word; word_vld pulses the cycle after the 4th byte.
// No backpressure: every qualified byte is consumed, clear discards any partial word.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic [31:0] word_dat,
    output logic        word_vld
);

    logic [1:0] byte_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word_dat <= 32'd0;
            byte_cnt <= 2'd0;
            word_vld <= 1'b0;
        end else begin
            word_vld <= byte_vld && (byte_cnt == 2'd3);
            if (byte_vld) begin
                word_dat <= {word_dat[23:0], byte_dat};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a program byte-serially into instruction memory, then gates the pipeline clock per host command;
// writes land one cycle after the 4th byte, no backpressure. STEP command exists only with PROGRAM_LOADER_STEP_EN.
module program_loader
    import pipeline_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              halt_seen,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              pipe_reset,
    output logic              pipe_clk_en,
    output logic              loaded,
    output logic              overflow,
    output logic [31:0]       cycle_count
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t      state;
    state_t      state_next;
    logic [31:0] word_dat;
    logic        word_vld;
    logic        write_fire;
    logic        at_top;
    logic        is_halt;
    logic        reload_cmd;
    logic        enter_load;

    word_assembler u_word_assembler (
        .clk      (clk),
        .reset    (reset),
        .clear    (enter_load),
        .byte_vld (rx_valid && (state == ST_LOAD)),
        .byte_dat (rx_data),
        .word_dat (word_dat),
        .word_vld (word_vld)
    );

    assign write_fire = word_vld && (state == ST_LOAD);
    assign at_top     = (imem_addr == ADDR_MAX);
    assign is_halt    = (word_dat == HALT_WORD);
    assign reload_cmd = rx_valid && (rx_data == CMD_RELOAD);
    assign enter_load = (state != ST_LOAD) && (state_next == ST_LOAD);

    // A write still pending from the last byte before reset must not reach memory.
    assign imem_we    = write_fire && !reset;
    assign imem_wdata = word_dat;
    assign pipe_reset = (state == ST_LOAD);
    assign loaded     = (state != ST_LOAD);

    always_comb begin
        state_next  = state;
        pipe_clk_en = 1'b0;
        case (state)
            ST_LOAD: begin
                if (write_fire && (is_halt || at_top)) begin
                    state_next = ST_WAIT_CMD;
                end
            end
            ST_WAIT_CMD: begin
                if (rx_valid) begin
                    if (rx_data == CMD_CONT) begin
                        state_next = ST_RUN;
                    end else if (rx_data == CMD_RELOAD) begin
                        state_next = ST_LOAD;
                    end
`ifdef PROGRAM_LOADER_STEP_EN
                    else if (rx_data == CMD_STEP) begin
                        state_next = ST_STEP;
                    end
`endif
                end
            end
            ST_RUN: begin
                pipe_clk_en = !halt_seen;
                // Reload has priority over a halt retiring in the same cycle.
                if (reload_cmd) begin
                    state_next = ST_LOAD;
                end else if (halt_seen) begin
                    state_next = ST_DONE;
                end
            end
`ifdef PROGRAM_LOADER_STEP_EN
            ST_STEP: begin
                pipe_clk_en = 1'b1;
                state_next  = ST_WAIT_CMD;
            end
`endif
            ST_DONE: begin
                if (reload_cmd) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_LOAD;
            imem_addr   <= '0;
            overflow    <= 1'b0;
            cycle_count <= 32'd0;
        end else begin
            state <= state_next;
            if (enter_load) begin
                imem_addr   <= '0;
                overflow    <= 1'b0;
                cycle_count <= 32'd0;
            end else begin
                // The top word is written but the address saturates rather than wrapping.
                if (write_fire && !at_top) begin
                    imem_addr <= imem_addr + ADDR_W'(1);
                end
                if (write_fire && at_top && !is_halt) begin
                    overflow <= 1'b1;
                end
                if (pipe_clk_en) begin
                    cycle_count <= cycle_count + 32'd1;
                end
            end
        end
    end

endmodule
